dmem_master: RTL and testbench
==============================

Name: dmem_master

Overview:
- Load/store initiator between the core's memory stage and the word-organised data memory.
- Accepts one load/store request at a time. Checks alignment. Issues word-aligned read/write transactions with a req/gnt/rvalid handshake.
- Sub-word stores are done as read-modify-write, because the memory supports whole-word writes only.
- Loads get byte/halfword extraction with sign or zero extension, and a single registered response goes back to the pipeline.

Parameters:
ADDR_W, 32, request/memory address width in bits.
TIMEOUT, 0, max cycles to wait for gnt or rvalid; 0 disables the timeout.

Ports:
clk_i  in  1  clock, all logic on rising edge.
rst_i  in  1  synchronous active-high reset.
req_valid_i  in  1  pipeline request valid.
req_ready_o  out  1  block can accept a request (high only in IDLE).
req_we_i  in  1  1 = store, 0 = load.
req_size_i  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
req_addr_i  in  ADDR_W  byte address.
req_wdata_i  in  32  store data, right-aligned.
resp_valid_o  out  1  response valid.
resp_ready_i  in  1  pipeline consumes response.
resp_rdata_o  out  32  extended load data; 0 for stores and errors.
resp_err_o  out  2  00 ok, 01 misaligned, 10 timeout.
mem_req_o  out  1  memory transaction request.
mem_we_o  out  1  memory write enable.
mem_addr_o  out  ADDR_W  word-aligned address, bits [1:0] always 0.
mem_wdata_o  out  32  full-word write data.
mem_gnt_i  in  1  memory accepted the transaction this cycle.
mem_rvalid_i  in  1  read data valid; may arrive earliest one cycle after gnt.
mem_rdata_i  in  32  read word.

Behaviour:
- Reset (sync, rst_i=1 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0, except req_ready_o=1 in IDLE.
  - Any in-flight transaction is abandoned with no response.
  - An rvalid arriving after reset is ignored.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP.
- Capture: on req_valid_i & req_ready_o, register we, size, addr, wdata. Next-state rules:
  - Misaligned request → RESP, err=01, no memory access.
    - Misaligned means H/HU/SH with addr[0]=1, or W/SW with addr[1:0]≠0.
  - Load, or store with size B/H → RD_REQ.
  - Store W → WR_REQ with mem_wdata_o = wdata.
- For stores, funct3 bit 2 is ignored (100 treated as B, 101 as H).
- RD_REQ:
  - Drives mem_req_o=1, mem_we_o=0, mem_addr_o = {addr[ADDR_W-1:2],2'b00}.
  - mem_req_o and mem_addr_o are held stable until mem_gnt_i.
  - On gnt → RD_WAIT.
- RD_WAIT: mem_req_o=0. On mem_rvalid_i:
  - Load: extract by addr[1:0] (byte lane = addr[1:0], half = addr[1]). Sign-extend for B/H, zero-extend for BU/HU/W. Result registered into resp_rdata_o, then → RESP.
  - Sub-word store: merge the new byte/half into the read word at that lane. Merged word registered into mem_wdata_o, then → WR_REQ.
- WR_REQ:
  - Drives mem_req_o=1, mem_we_o=1, stable address and data until gnt.
  - On gnt → RESP, rdata=0, err=00.
- RESP:
  - resp_valid_o=1, with data/err held until resp_ready_i.
  - On handshake → IDLE.
  - req_ready_o=0, so a new request is not accepted in the same cycle.
- Latency with gnt in the same cycle as req and rvalid one cycle later:
  - Load: resp_valid_o 3 cycles after acceptance.
  - SW: 2 cycles.
  - SB/SH: 4 cycles.
  - Misaligned: 1 cycle.
- Timeout (TIMEOUT>0):
  - A counter resets on entry to RD_REQ, RD_WAIT or WR_REQ and increments each cycle spent there.
  - When it reaches TIMEOUT: drop mem_req_o, → RESP with err=10, rdata=0. A partial RMW is not written.
- mem_gnt_i or mem_rvalid_i outside the waiting states is ignored.
- Only one transaction is outstanding at a time.

Test Plan:
- LW at 0x100, memory word 0xDEADBEEF, gnt immediate, rvalid +1 → mem_addr_o=0x100, mem_we_o=0; resp_rdata_o=0xDEADBEEF, err=00, resp_valid_o 3 cycles after acceptance.
- LB at 0x103 and LBU at 0x103, word 0x80FF1234 → 0xFFFFFF80 and 0x00000080. LH at 0x102 → 0xFFFF80FF; LHU at 0x102 → 0x000080FF.
- SB 0xAB at 0x101, word 0x11223344 → read at 0x100, then write mem_wdata_o=0x1122AB44 to 0x100. SH 0xBEEF at 0x102 → write 0xBEEF3344 over 0x11223344.
- LW at 0x102 and SH at 0x101 → no mem_req_o asserted; resp err=01, rdata=0 one cycle after acceptance.
- gnt delayed 3 cycles, resp_ready_i low 2 cycles → mem_req_o/addr/we/wdata stable throughout; resp_valid_o and data held; req_ready_o=0 until the RESP handshake.
- TIMEOUT=4 with gnt never asserted → err=10 after 4 cycles in RD_REQ, no write issued. Separately, rst_i=1 during RD_WAIT of an SB → IDLE, mem_req_o=0, no resp_valid_o, and a later stray rvalid is ignored.

Source files
------------

// File: rtl/dmem_master_if.sv
// Signal bundle between dmem_master, the pipeline memory stage and the data memory.
interface dmem_master_if #(parameter int ADDR_W = 32);
  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [2:0]        req_size_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [31:0]       req_wdata_i;
  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [31:0]       resp_rdata_o;
  logic [1:0]        resp_err_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [31:0]       mem_rdata_i;

  modport master (
    input  req_valid_i, req_we_i, req_size_i, req_addr_i, req_wdata_i, resp_ready_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_size_i, req_addr_i, req_wdata_i, resp_ready_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dmem_master.sv
// Single-outstanding load/store initiator: alignment check, word-only memory
// accesses, read-modify-write for sub-word stores, load extraction/extension.
module dmem_master #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  dmem_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_t;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [1:0] ERR_OK = 2'b00, ERR_MIS = 2'b01, ERR_TMO = 2'b10;

  state_t            state_q, state_n;
  logic              we_q;
  logic [2:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic [31:0]       rdata_q, mwdata_q;
  logic [1:0]        err_q;
  logic [CNT_W-1:0]  cnt_q;

  logic        accept, misaligned, tmo, tmo_hit;
  logic        req_ready, resp_valid, mem_req, mem_we;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_val, merge_val;

  assign accept = (state_q == IDLE) && bus.req_valid_i;
  assign tmo    = (TIMEOUT > 0) && (cnt_q == TMO_LAST);

  // Size decode uses funct3[1:0] only; bit 2 is just the zero-extend flag.
  always_comb begin
    unique case (bus.req_size_i[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = bus.req_addr_i[0];
      default: misaligned = |bus.req_addr_i[1:0];
    endcase
  end

  always_comb begin
    byte_lane = bus.mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    half_lane = addr_q[1] ? bus.mem_rdata_i[31:16] : bus.mem_rdata_i[15:0];
    unique case (size_q[1:0])
      2'b00:   load_val = {{24{byte_lane[7] & ~size_q[2]}}, byte_lane};
      2'b01:   load_val = {{16{half_lane[15] & ~size_q[2]}}, half_lane};
      default: load_val = bus.mem_rdata_i;
    endcase
  end

  always_comb begin
    merge_val = bus.mem_rdata_i;
    if (size_q[0]) merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q;
    else           merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
  end

  always_comb begin
    state_n    = state_q;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    tmo_hit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid_i) begin
          if (misaligned)                             state_n = RESP;
          else if (bus.req_we_i && bus.req_size_i[1]) state_n = WR_REQ;
          else                                        state_n = RD_REQ;
        end
      end
      RD_REQ: begin
        mem_req = 1'b1;
        if (bus.mem_gnt_i) state_n = RD_WAIT;
        else if (tmo) begin state_n = RESP; tmo_hit = 1'b1; end
      end
      RD_WAIT: begin
        if (bus.mem_rvalid_i) state_n = we_q ? WR_REQ : RESP;
        else if (tmo) begin state_n = RESP; tmo_hit = 1'b1; end
      end
      WR_REQ: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (bus.mem_gnt_i) state_n = RESP;
        else if (tmo) begin state_n = RESP; tmo_hit = 1'b1; end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (bus.resp_ready_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      mwdata_q <= '0;
      err_q    <= ERR_OK;
      cnt_q    <= '0;
    end else begin
      state_q <= state_n;
      // Restarts on every state change, so each wait state gets a full budget.
      cnt_q   <= (state_n != state_q) ? '0 : cnt_q + 1'b1;
      if (accept) begin
        we_q     <= bus.req_we_i;
        size_q   <= bus.req_size_i;
        addr_q   <= bus.req_addr_i;
        wdata_q  <= bus.req_wdata_i[15:0];
        mwdata_q <= bus.req_wdata_i;
        rdata_q  <= '0;
        err_q    <= misaligned ? ERR_MIS : ERR_OK;
      end
      if (state_q == RD_WAIT && bus.mem_rvalid_i) begin
        if (we_q) mwdata_q <= merge_val;
        else      rdata_q  <= load_val;
      end
      if (tmo_hit) begin
        rdata_q <= '0;
        err_q   <= ERR_TMO;
      end
    end
  end

  assign bus.req_ready_o  = req_ready;
  assign bus.resp_valid_o = resp_valid;
  assign bus.resp_rdata_o = rdata_q;
  assign bus.resp_err_o   = err_q;
  assign bus.mem_req_o    = mem_req;
  assign bus.mem_we_o     = mem_we;
  assign bus.mem_addr_o   = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.mem_wdata_o  = mwdata_q;

endmodule

// File: tb/tb_dmem_master.sv
// Bench for dmem_master: random load/store traffic against a transaction-level
// model and a random-latency memory, plus directed latency, reset and timeout cases.
module tb_dmem_master;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_master_if #(.ADDR_W(AW)) b ();
  dmem_master_if #(.ADDR_W(AW)) bt ();

  dmem_master #(.ADDR_W(AW), .TIMEOUT(0)) dut    (.clk_i(clk), .rst_i(rst), .bus(b));
  dmem_master #(.ADDR_W(AW), .TIMEOUT(4)) dut_to (.clk_i(clk), .rst_i(rst), .bus(bt));

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  // Memory-side knobs, written only by the main sequence.
  int gmin = 0, gmax = 0, rmin = 0, rmax = 0;
  bit chk_on = 1'b0;

  logic [31:0] mem     [16];   // what the memory really holds
  logic [31:0] ref_mem [16];   // what it should hold

  // ---------------- memory responder ----------------
  int          gdly, rvcnt;
  bit          gpend, rvpend;
  logic [31:0] rvword;
  initial begin
    gpend = 1'b0; rvpend = 1'b0; gdly = 0; rvcnt = 0; rvword = '0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h9E3779B9 * (i + 1);
    b.mem_gnt_i = 1'b0; b.mem_rvalid_i = 1'b0; b.mem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      b.mem_gnt_i = 1'b0; b.mem_rvalid_i = 1'b0; b.mem_rdata_i = $urandom;
      if (rvpend) begin
        if (rvcnt == 0) begin b.mem_rvalid_i = 1'b1; b.mem_rdata_i = rvword; rvpend = 1'b0; end
        else rvcnt--;
      end
      if (b.mem_req_o && !rst) begin
        if (!gpend) begin gpend = 1'b1; gdly = $urandom_range(gmin, gmax); end
        if (gdly == 0) begin
          gpend = 1'b0;
          b.mem_gnt_i = 1'b1;
          if (b.mem_we_o) mem[b.mem_addr_o[5:2]] = b.mem_wdata_o;
          else begin
            rvpend = 1'b1;
            rvcnt  = $urandom_range(rmin, rmax);
            rvword = mem[b.mem_addr_o[5:2]];
          end
        end else gdly--;
      end
    end
  end

  // ---------------- reference model + per-cycle compare ----------------
  op_t         op_q[$];
  bit          busy;
  logic [31:0] exp_rdata;
  logic [1:0]  exp_err;

  task automatic model_accept(input bit we, input logic [2:0] sz, input logic [31:0] a,
                              input logic [31:0] wd);
    int          nb, off;
    logic [31:0] w, wa, mask, v;
    nb  = (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
    off = int'(a[1:0]);
    wa  = a & ~32'h3;
    w   = ref_mem[a[5:2]];
    exp_rdata = '0;
    exp_err   = 2'b00;
    if ((off % nb) != 0) begin exp_err = 2'b01; return; end
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 1);
    if (!we) begin
      op_q.push_back('{1'b0, wa, 32'h0});
      v = (w >> (8 * off)) & mask;
      if (nb < 4 && !sz[2] && v[8*nb-1]) v = v | ~mask;
      exp_rdata = v;
    end else if (nb == 4) begin
      op_q.push_back('{1'b1, wa, wd});
    end else begin
      op_q.push_back('{1'b0, wa, 32'h0});
      op_q.push_back('{1'b1, wa, (w & ~(mask << (8 * off))) | ((wd & mask) << (8 * off))});
    end
  endtask

  initial begin
    busy = 1'b0; exp_rdata = '0; exp_err = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h9E3779B9 * (i + 1);
    forever begin
      @(negedge clk);
      if (rst) begin
        op_q.delete();
        busy = 1'b0;
      end else if (chk_on) begin
        chk("req_ready", b.req_ready_o, !busy);
        if (b.mem_req_o) begin
          chk("mem_req_expected", b.mem_req_o, op_q.size() != 0);
          if (op_q.size() != 0) begin
            chk("mem_we", b.mem_we_o, op_q[0].we);
            chk("mem_addr", b.mem_addr_o, op_q[0].addr);
            if (op_q[0].we) chk("mem_wdata", b.mem_wdata_o, op_q[0].data);
            if (b.mem_gnt_i) begin
              if (op_q[0].we) ref_mem[op_q[0].addr[5:2]] = op_q[0].data;
              void'(op_q.pop_front());
            end
          end
        end
        if (b.resp_valid_o) begin
          chk("resp_valid_due", b.resp_valid_o, busy && op_q.size() == 0);
          if (busy && op_q.size() == 0) begin
            chk("resp_rdata", b.resp_rdata_o, exp_rdata);
            chk("resp_err", b.resp_err_o, exp_err);
            if (b.resp_ready_i) busy = 1'b0;
          end
        end
        if (b.req_valid_i && !busy) begin
          busy = 1'b1;
          model_accept(b.req_we_i, b.req_size_i, b.req_addr_i, b.req_wdata_i);
        end
      end
    end
  end

  // ---------------- request driver ----------------
  task automatic do_req(input bit we, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic [1:0] er, output int lat);
    int n;
    n = 0; rd = '0; er = '0; lat = 0;
    b.req_valid_i = 1'b1; b.req_we_i = we; b.req_size_i = sz;
    b.req_addr_i = a; b.req_wdata_i = wd;
    while (!b.req_ready_o && n < 100) begin @(posedge clk); #1; n++; end
    chk("req_ready_for_accept", b.req_ready_o, 1);
    @(posedge clk); #1;
    // Scramble the request bus so the DUT must use its captured copy.
    b.req_valid_i = 1'b0; b.req_we_i = 1'($urandom); b.req_size_i = 3'($urandom);
    b.req_addr_i = $urandom; b.req_wdata_i = $urandom;
    lat = 1;
    while (!b.resp_valid_o && lat < 300) begin @(posedge clk); #1; lat++; end
    chk("resp_arrived", b.resp_valid_o, 1);
    if (!b.resp_valid_o) return;
    rd = b.resp_rdata_o;
    er = b.resp_err_o;
    repeat (hold) begin @(posedge clk); #1; end
    b.resp_ready_i = 1'b1;
    @(posedge clk); #1;
    b.resp_ready_i = 1'b0;
  endtask

  logic [2:0] szs [5];

  initial begin
    logic [31:0] rd;
    logic [1:0]  er;
    int          lat, n, wr_seen;

    szs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    rst = 1'b1;
    b.req_valid_i = 1'b0; b.req_we_i = 1'b0; b.req_size_i = '0; b.req_addr_i = '0;
    b.req_wdata_i = '0; b.resp_ready_i = 1'b0;
    bt.req_valid_i = 1'b0; bt.req_we_i = 1'b0; bt.req_size_i = '0; bt.req_addr_i = '0;
    bt.req_wdata_i = '0; bt.resp_ready_i = 1'b0;
    bt.mem_gnt_i = 1'b0; bt.mem_rvalid_i = 1'b0; bt.mem_rdata_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_req_ready", b.req_ready_o, 1);
    chk("rst_resp_valid", b.resp_valid_o, 0);
    chk("rst_mem_req", b.mem_req_o, 0);
    chk("rst_mem_we", b.mem_we_o, 0);
    chk("rst_mem_addr", b.mem_addr_o, 0);
    chk("rst_mem_wdata", b.mem_wdata_o, 0);
    chk("rst_resp_rdata", b.resp_rdata_o, 0);
    chk("rst_resp_err", b.resp_err_o, 0);
    chk_on = 1'b1;

    // Immediate gnt, rvalid one cycle later.
    gmin = 0; gmax = 0; rmin = 0; rmax = 0;
    do_req(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, rd, er, lat);
    chk("sw_lat", lat, 2);
    chk("sw_mem", mem[0], 32'hDEADBEEF);
    do_req(0, 3'b010, 32'h100, 32'h0, 0, rd, er, lat);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_err", er, 2'b00);
    chk("lw_lat", lat, 3);

    do_req(1, 3'b010, 32'h100, 32'h80FF1234, 0, rd, er, lat);
    do_req(0, 3'b000, 32'h103, 32'h0, 0, rd, er, lat); chk("lb_103", rd, 32'hFFFFFF80);
    do_req(0, 3'b100, 32'h103, 32'h0, 0, rd, er, lat); chk("lbu_103", rd, 32'h00000080);
    do_req(0, 3'b001, 32'h102, 32'h0, 0, rd, er, lat); chk("lh_102", rd, 32'hFFFF80FF);
    do_req(0, 3'b101, 32'h102, 32'h0, 0, rd, er, lat); chk("lhu_102", rd, 32'h000080FF);

    do_req(1, 3'b010, 32'h100, 32'h11223344, 0, rd, er, lat);
    do_req(1, 3'b000, 32'h101, 32'h000000AB, 0, rd, er, lat);
    chk("sb_lat", lat, 4);
    chk("sb_mem", mem[0], 32'h1122AB44);
    do_req(1, 3'b010, 32'h100, 32'h11223344, 0, rd, er, lat);
    do_req(1, 3'b001, 32'h102, 32'h0000BEEF, 0, rd, er, lat);
    chk("sh_mem", mem[0], 32'hBEEF3344);
    chk("sh_rdata", rd, 32'h0);

    do_req(0, 3'b010, 32'h102, 32'h0, 0, rd, er, lat);
    chk("lw_mis_err", er, 2'b01); chk("lw_mis_rdata", rd, 0); chk("lw_mis_lat", lat, 1);
    do_req(1, 3'b001, 32'h101, 32'h5555, 0, rd, er, lat);
    chk("sh_mis_err", er, 2'b01); chk("sh_mis_lat", lat, 1);
    chk("sh_mis_nowrite", mem[0], 32'hBEEF3344);

    // Slow gnt and stalled consumer.
    gmin = 3; gmax = 3; rmin = 0; rmax = 0;
    do_req(0, 3'b010, 32'h100, 32'h0, 2, rd, er, lat);
    chk("slow_lat", lat, 6);
    chk("slow_data", rd, 32'hBEEF3344);

    // Random traffic.
    gmin = 0; gmax = 3; rmin = 0; rmax = 3;
    for (int i = 0; i < 150; i++) begin
      bit          we;
      logic [2:0]  sz;
      logic [31:0] a;
      we = 1'($urandom_range(0, 1));
      sz = szs[$urandom_range(0, 4)];
      a  = 32'h100 + $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) begin
        if (sz[1]) a[1:0] = 2'b00;
        else if (sz[0]) a[0] = 1'b0;
      end
      do_req(we, sz, a, $urandom, $urandom_range(0, 2), rd, er, lat);
    end

    // Reset during the read phase of an SB; the later rvalid must be ignored.
    gmin = 0; gmax = 0; rmin = 2; rmax = 2;
    do_req(1, 3'b010, 32'h104, 32'h77665544, 0, rd, er, lat);
    b.req_valid_i = 1'b1; b.req_we_i = 1'b1; b.req_size_i = 3'b000;
    b.req_addr_i = 32'h105; b.req_wdata_i = 32'h5A;
    @(posedge clk); #1;
    b.req_valid_i = 1'b0;
    chk("rst_sb_rdreq", b.mem_req_o, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_mem_req", b.mem_req_o, 0);
    chk("rst_mid_resp_valid", b.resp_valid_o, 0);
    chk("rst_mid_req_ready", b.req_ready_o, 1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("rst_mid_no_resp", b.resp_valid_o, 0);
      chk("rst_mid_no_req", b.mem_req_o, 0);
    end
    chk("rst_mid_no_write", mem[1], 32'h77665544);
    gmin = 0; gmax = 0; rmin = 0; rmax = 0;
    do_req(0, 3'b010, 32'h104, 32'h0, 0, rd, er, lat);
    chk("post_rst_lw", rd, 32'h77665544);
    chk("post_rst_lat", lat, 3);

    // Timeout instance: gnt never comes.
    bt.req_valid_i = 1'b1; bt.req_we_i = 1'b0; bt.req_size_i = 3'b010; bt.req_addr_i = 32'h100;
    @(posedge clk); #1;
    bt.req_valid_i = 1'b0;
    n = 0;
    while (bt.mem_req_o && n < 20) begin n++; @(posedge clk); #1; end
    chk("tmo_rd_req_cycles", n, 4);
    chk("tmo_rd_valid", bt.resp_valid_o, 1);
    chk("tmo_rd_err", bt.resp_err_o, 2'b10);
    chk("tmo_rd_rdata", bt.resp_rdata_o, 0);
    bt.resp_ready_i = 1'b1; @(posedge clk); #1; bt.resp_ready_i = 1'b0;
    chk("tmo_rd_idle", bt.req_ready_o, 1);

    // Timeout instance: SB read granted but rvalid never comes; no write allowed.
    bt.req_valid_i = 1'b1; bt.req_we_i = 1'b1; bt.req_size_i = 3'b000;
    bt.req_addr_i = 32'h102; bt.req_wdata_i = 32'hAB;
    @(posedge clk); #1;
    bt.req_valid_i = 1'b0;
    chk("tmo_sb_rdreq", bt.mem_req_o, 1);
    bt.mem_gnt_i = 1'b1;
    @(posedge clk); #1;
    bt.mem_gnt_i = 1'b0;
    n = 0; wr_seen = 0;
    while (!bt.resp_valid_o && n < 20) begin
      if (bt.mem_req_o) wr_seen++;
      n++;
      @(posedge clk); #1;
    end
    chk("tmo_sb_wait_cycles", n, 4);
    chk("tmo_sb_no_write", wr_seen, 0);
    chk("tmo_sb_err", bt.resp_err_o, 2'b10);
    chk("tmo_sb_rdata", bt.resp_rdata_o, 0);
    bt.resp_ready_i = 1'b1; @(posedge clk); #1; bt.resp_ready_i = 1'b0;

    for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
